// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage LoongArch pipeline: holds one EXE result,
// waits for variable-latency data-SRAM load data, extends it, forwards and hands it to WB.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 75,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ms_to_ds_valid,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_forward_bus,
  input  logic                       data_sram_rvalid,
  input  logic [31:0]                data_sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HAVE = 2'd2
  } ms_state_t;

  ms_state_t                  state;
  ms_state_t                  state_next;
  logic                       ms_valid;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
  logic [31:0]                data_buf;
  logic                       buf_load;

  logic        ms_unsigned;
  logic [1:0]  ms_size;
  logic        ms_store;
  logic        ms_load;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_pc;
  logic        es_load;

  logic [31:0] raw_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic        out_gr_we;
  logic        accept;

  assign {ms_unsigned, ms_size, ms_store, ms_load, ms_gr_we,
          ms_dest, ms_alu_result, ms_pc} = es_bus_r;
  assign es_load = es_to_ms_bus[70];

  // Handshake with EXE and WB
  assign ms_ready_go    = !ms_load || (state == HAVE) || ((state == WAIT) && data_sram_rvalid);
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      es_bus_r <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (accept)     es_bus_r <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      data_buf <= 32'd0;
    end else begin
      state <= state_next;
      if (buf_load) data_buf <= data_sram_rdata;
    end
  end

  // A retire always hands the FSM to whatever is accepted behind it; a response
  // that WB cannot take yet is parked in the buffer.
  always_comb begin
    state_next = state;
    buf_load   = 1'b0;
    if (ms_allowin) begin
      state_next = (es_to_ms_valid && es_load) ? WAIT : IDLE;
    end else if (ms_valid && (state == WAIT) && data_sram_rvalid) begin
      state_next = HAVE;
      buf_load   = 1'b1;
    end
  end

  always_comb begin
    raw_data = (state == HAVE) ? data_buf : data_sram_rdata;
    case (ms_alu_result[1:0])
      2'd0:    byte_sel = raw_data[7:0];
      2'd1:    byte_sel = raw_data[15:8];
      2'd2:    byte_sel = raw_data[23:16];
      default: byte_sel = raw_data[31:24];
    endcase
    half_sel = ms_alu_result[1] ? raw_data[31:16] : raw_data[15:0];
    case (ms_size)
      2'd0:    load_result = {{24{!ms_unsigned && byte_sel[7]}}, byte_sel};
      2'd1:    load_result = {{16{!ms_unsigned && half_sel[15]}}, half_sel};
      default: load_result = raw_data;
    endcase
  end

  assign final_result = ms_load ? load_result : ms_alu_result;
  assign out_gr_we    = ms_gr_we && !ms_store;

  assign ms_to_ws_bus   = {out_gr_we, ms_dest, final_result, ms_pc};
  assign ms_to_ds_valid = ms_valid;

  // Bit 0 tells DECODE whether the forwarded value is usable yet.
  assign ms_to_ds_forward_bus = {out_gr_we && ms_valid, ms_dest, final_result,
                                 ms_valid && (!ms_load || ms_ready_go)};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extraction, variable latency,
// WB backpressure with buffered data, back-to-back flow and reset during a wait.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        ms_to_ds_valid;
  logic [38:0] ms_to_ds_forward_bus;
  logic        data_sram_rvalid;
  logic [31:0] data_sram_rdata;

  int vectors;
  int miscompares;

  mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .ws_allowin           (ws_allowin),
    .ms_allowin           (ms_allowin),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .ms_to_ws_valid       (ms_to_ws_valid),
    .ms_to_ws_bus         (ms_to_ws_bus),
    .ms_to_ds_valid       (ms_to_ds_valid),
    .ms_to_ds_forward_bus (ms_to_ds_forward_bus),
    .data_sram_rvalid     (data_sram_rvalid),
    .data_sram_rdata      (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [74:0] mkBus(input logic uns, input logic [1:0] size,
                                        input logic store, input logic load,
                                        input logic gr_we, input logic [4:0] dest,
                                        input logic [31:0] alu, input logic [31:0] pc);
    return {uns, size, store, load, gr_we, dest, alu, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic es_valid, input logic [74:0] bus,
                               input logic rvalid, input logic [31:0] rdata,
                               input logic ws_in);
    es_to_ms_valid   = es_valid;
    es_to_ms_bus     = bus;
    data_sram_rvalid = rvalid;
    data_sram_rdata  = rdata;
    ws_allowin       = ws_in;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [74:0] observed,
                             input logic [74:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic runLoad(input string tag, input logic [74:0] bus,
                         input logic [31:0] rdata, input logic [31:0] expected);
    applyStimulus(1'b1, bus, 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, rdata, 1'b1);
    checkOutput({tag, "_valid"}, 75'(ms_to_ws_valid), 75'd1);
    checkOutput({tag, "_result"}, 75'(ms_to_ws_bus[63:32]), 75'(expected));
    tick();
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
    tick();
    tick();
    checkOutput("rst_ws_valid", 75'(ms_to_ws_valid), 75'd0);
    checkOutput("rst_ds_valid", 75'(ms_to_ds_valid), 75'd0);
    checkOutput("rst_fwd_we", 75'(ms_to_ds_forward_bus[38]), 75'd0);
    checkOutput("rst_fwd_rdy", 75'(ms_to_ds_forward_bus[0]), 75'd0);
    checkOutput("rst_allowin", 75'(ms_allowin), 75'd1);
    reset = 1'b0;

    $display("[TB] ld.w with single-cycle response");
    applyStimulus(1'b1, mkBus(0, 2'd2, 0, 1, 1, 5'd5, 32'h1000, 32'h1c00_0000),
                  1'b0, 32'd0, 1'b1);
    checkOutput("t1_allowin_accept", 75'(ms_allowin), 75'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'h8765_4321, 1'b1);
    checkOutput("t1_ws_valid", 75'(ms_to_ws_valid), 75'd1);
    checkOutput("t1_ws_bus", 75'(ms_to_ws_bus),
                75'({1'b1, 5'd5, 32'h8765_4321, 32'h1c00_0000}));
    checkOutput("t1_allowin_retire", 75'(ms_allowin), 75'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
    checkOutput("t1_ws_valid_after", 75'(ms_to_ws_valid), 75'd0);
    checkOutput("t1_allowin_after", 75'(ms_allowin), 75'd1);

    $display("[TB] load extraction");
    runLoad("ld_b_a3", mkBus(0, 2'd0, 0, 1, 1, 5'd3, 32'h1003, 32'h10), 32'h80FF_0000, 32'hFFFF_FF80);
    runLoad("ld_bu_a3", mkBus(1, 2'd0, 0, 1, 1, 5'd3, 32'h1003, 32'h14), 32'h80FF_0000, 32'h0000_0080);
    runLoad("ld_b_a1", mkBus(0, 2'd0, 0, 1, 1, 5'd3, 32'h1001, 32'h18), 32'h0000_7F00, 32'h0000_007F);
    runLoad("ld_h_a2", mkBus(0, 2'd1, 0, 1, 1, 5'd4, 32'h1002, 32'h1c), 32'h8001_1234, 32'hFFFF_8001);
    runLoad("ld_hu_a3", mkBus(1, 2'd1, 0, 1, 1, 5'd4, 32'h1003, 32'h20), 32'h8001_1234, 32'h0000_8001);
    runLoad("ld_h_a1", mkBus(0, 2'd1, 0, 1, 1, 5'd4, 32'h1001, 32'h24), 32'h8001_9234, 32'hFFFF_9234);
    runLoad("ld_wu", mkBus(1, 2'd2, 0, 1, 1, 5'd4, 32'h1003, 32'h28), 32'h8765_4321, 32'h8765_4321);

    $display("[TB] delayed response");
    applyStimulus(1'b1, mkBus(0, 2'd2, 0, 1, 1, 5'd6, 32'h2000, 32'h40), 1'b0, 32'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 32'hFFFF_FFFF, 1'b1);
      checkOutput("t3_ws_valid_wait", 75'(ms_to_ws_valid), 75'd0);
      checkOutput("t3_fwd_rdy_wait", 75'(ms_to_ds_forward_bus[0]), 75'd0);
      checkOutput("t3_allowin_wait", 75'(ms_allowin), 75'd0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b1, 32'h1122_3344, 1'b1);
    checkOutput("t3_ws_valid", 75'(ms_to_ws_valid), 75'd1);
    checkOutput("t3_result", 75'(ms_to_ws_bus[63:32]), 75'h1122_3344);
    checkOutput("t3_fwd", 75'(ms_to_ds_forward_bus), 75'({1'b1, 5'd6, 32'h1122_3344, 1'b1}));
    tick();

    $display("[TB] WB backpressure with buffered data");
    applyStimulus(1'b1, mkBus(0, 2'd2, 0, 1, 1, 5'd10, 32'h2004, 32'h50), 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("t4_ws_valid_rv", 75'(ms_to_ws_valid), 75'd1);
    checkOutput("t4_allowin_rv", 75'(ms_allowin), 75'd0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b0);
    checkOutput("t4_have_valid", 75'(ms_to_ws_valid), 75'd1);
    checkOutput("t4_have_result", 75'(ms_to_ws_bus[63:32]), 75'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_1234, 1'b0);
    checkOutput("t4_spurious_result", 75'(ms_to_ws_bus[63:32]), 75'hDEAD_BEEF);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
    checkOutput("t4_retire_bus", 75'(ms_to_ws_bus), 75'({1'b1, 5'd10, 32'hDEAD_BEEF, 32'h50}));
    checkOutput("t4_retire_allowin", 75'(ms_allowin), 75'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
    checkOutput("t4_empty", 75'(ms_to_ws_valid), 75'd0);

    $display("[TB] back-to-back add/store/load");
    applyStimulus(1'b1, mkBus(0, 2'd2, 0, 0, 1, 5'd7, 32'h30, 32'h60), 1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b1, mkBus(0, 2'd2, 1, 0, 1, 5'd8, 32'h44, 32'h64), 1'b0, 32'd0, 1'b1);
    checkOutput("t5_add_bus", 75'(ms_to_ws_bus), 75'({1'b1, 5'd7, 32'h30, 32'h60}));
    checkOutput("t5_add_fwd", 75'(ms_to_ds_forward_bus), 75'({1'b1, 5'd7, 32'h30, 1'b1}));
    checkOutput("t5_add_valid", 75'(ms_to_ws_valid), 75'd1);
    tick();
    applyStimulus(1'b1, mkBus(0, 2'd2, 0, 1, 1, 5'd9, 32'h50, 32'h68), 1'b0, 32'd0, 1'b1);
    checkOutput("t5_st_bus", 75'(ms_to_ws_bus), 75'({1'b0, 5'd8, 32'h44, 32'h64}));
    checkOutput("t5_st_fwd_we", 75'(ms_to_ds_forward_bus[38]), 75'd0);
    checkOutput("t5_st_valid", 75'(ms_to_ws_valid), 75'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'hCAFE_F00D, 1'b1);
    checkOutput("t5_ld_bus", 75'(ms_to_ws_bus), 75'({1'b1, 5'd9, 32'hCAFE_F00D, 32'h68}));
    checkOutput("t5_ld_valid", 75'(ms_to_ws_valid), 75'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
    checkOutput("t5_drained", 75'(ms_to_ws_valid), 75'd0);

    $display("[TB] reset while waiting for load data");
    applyStimulus(1'b1, mkBus(0, 2'd2, 0, 1, 1, 5'd11, 32'h3000, 32'h70), 1'b0, 32'd0, 1'b1);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
    checkOutput("t6_wait_allowin", 75'(ms_allowin), 75'd0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 32'd0, 1'b1);
    checkOutput("t6_ds_valid", 75'(ms_to_ds_valid), 75'd0);
    checkOutput("t6_allowin", 75'(ms_allowin), 75'd1);
    checkOutput("t6_ws_valid", 75'(ms_to_ws_valid), 75'd0);
    runLoad("t6_after", mkBus(0, 2'd0, 0, 1, 1, 5'd12, 32'h3002, 32'h74), 32'h0081_0000, 32'hFFFF_FF81);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
